// File: rtl/l2_arbiter_pkg.sv
// Shared types for the LC-3b memory hierarchy, including the L2 arbiter
// state encoding and its reset-time round-robin pointer.
package lc3b_types;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_line;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_SERVE_I,
        ARB_SERVE_D
    } l2_arb_state_t;

    // Pointing at D after reset means I wins the first conflict.
    localparam logic ARB_RESET_LAST_IS_D = 1'b1;

endpackage

// File: rtl/l2_arbiter_fsm.sv
// Grant FSM for the L2 arbiter: round-robin between I and D, one grant per
// transaction, with an IDLE bubble after every L2 response.
// Optional macro L2_ARBITER_PERF_EN adds grant/conflict counters.
//
// state       | meaning
// ARB_IDLE    | no grant, arbitrating incoming requests
// ARB_SERVE_I | I-cache owns L2 until L2_resp
// ARB_SERVE_D | D-cache owns L2 until L2_resp
module l2_arbiter_fsm
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        req_d,
    input  logic        l2_resp,
`ifdef L2_ARBITER_PERF_EN
    output logic [31:0] perf_i_grants,
    output logic [31:0] perf_d_grants,
    output logic [31:0] perf_conflicts,
`endif
    output logic        sel_d,
    output logic        grant_valid
);

    l2_arb_state_t state;
    logic          last_is_d;
    logic          pick_i;

    // On a conflict the requester not served last wins.
    assign pick_i = req_i && (!req_d || last_is_d);

    // Grant state, round-robin pointer and registered steering controls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ARB_IDLE;
            last_is_d   <= ARB_RESET_LAST_IS_D;
            sel_d       <= 1'b0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                ARB_IDLE: begin
                    if (pick_i) begin
                        state       <= ARB_SERVE_I;
                        sel_d       <= 1'b0;
                        grant_valid <= 1'b1;
                    end else if (req_d) begin
                        state       <= ARB_SERVE_D;
                        sel_d       <= 1'b1;
                        grant_valid <= 1'b1;
                    end
                end
                ARB_SERVE_I, ARB_SERVE_D: begin
                    if (l2_resp) begin
                        state       <= ARB_IDLE;
                        last_is_d   <= (state == ARB_SERVE_D);
                        sel_d       <= 1'b0;
                        grant_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= ARB_IDLE;
                    sel_d       <= 1'b0;
                    grant_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef L2_ARBITER_PERF_EN
    // Free-running wrap-around counters of grants and IDLE-cycle conflicts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_i_grants  <= '0;
            perf_d_grants  <= '0;
            perf_conflicts <= '0;
        end else if (state == ARB_IDLE) begin
            if (pick_i)
                perf_i_grants <= perf_i_grants + 32'd1;
            else if (req_d)
                perf_d_grants <= perf_d_grants + 32'd1;
            if (req_i && req_d)
                perf_conflicts <= perf_conflicts + 32'd1;
        end
    end
`endif

endmodule

// File: rtl/l2_arbiter.sv
// L2 port arbiter between I-cache and D-cache: grant FSM plus the address,
// write-data and read-data steering muxes. Caches and L2 connect directly.
// Optional macro L2_ARBITER_PERF_EN exposes 32-bit perf counters.
module l2_arbiter
    import lc3b_types::*;
#(
    parameter int ADDR_W = $bits(lc3b_word),
    parameter int LINE_W = $bits(lc3b_line)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              I_read,
    input  logic              I_write,
    input  logic [ADDR_W-1:0] I_addr,
    input  logic [LINE_W-1:0] I_wdata,
    output logic [LINE_W-1:0] I_rdata,
    output logic              I_resp,
    input  logic              D_read,
    input  logic              D_write,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic [LINE_W-1:0] D_wdata,
    output logic [LINE_W-1:0] D_rdata,
    output logic              D_resp,
    output logic              L2_read,
    output logic              L2_write,
    output logic [ADDR_W-1:0] L2_addr,
    output logic [LINE_W-1:0] L2_wdata,
    input  logic [LINE_W-1:0] L2_rdata,
`ifdef L2_ARBITER_PERF_EN
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_conflicts,
`endif
    input  logic              L2_resp
);

    logic sel_d;
    logic grant_valid;

    l2_arbiter_fsm u_fsm (
        .clk            (clk),
        .rst            (rst),
        .req_i          (I_read | I_write),
        .req_d          (D_read | D_write),
        .l2_resp        (L2_resp),
`ifdef L2_ARBITER_PERF_EN
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts),
`endif
        .sel_d          (sel_d),
        .grant_valid    (grant_valid)
    );

    // Steer the owner's request to L2 and L2's reply to the owner only.
    always_comb begin
        L2_read  = 1'b0;
        L2_write = 1'b0;
        L2_addr  = '0;
        L2_wdata = '0;
        I_rdata  = '0;
        I_resp   = 1'b0;
        D_rdata  = '0;
        D_resp   = 1'b0;
        if (grant_valid) begin
            if (sel_d) begin
                L2_read  = D_read;
                L2_write = D_write;
                L2_addr  = D_addr;
                L2_wdata = D_wdata;
                D_rdata  = L2_rdata;
                D_resp   = L2_resp;
            end else begin
                L2_read  = I_read;
                L2_write = I_write;
                L2_addr  = I_addr;
                L2_wdata = I_wdata;
                I_rdata  = L2_rdata;
                I_resp   = L2_resp;
            end
        end
    end

endmodule

// File: tb/tb_l2_arbiter.sv
// Self-checking bench for l2_arbiter: directed scenarios plus a randomized
// run against a transaction-level ownership model.
module tb_l2_arbiter;

    localparam int AW = 16;
    localparam int LW = 128;

    logic          clk = 1'b0;
    logic          rst;
    logic          I_read, I_write, D_read, D_write;
    logic [AW-1:0] I_addr, D_addr, L2_addr;
    logic [LW-1:0] I_wdata, D_wdata, L2_wdata, I_rdata, D_rdata, L2_rdata;
    logic          I_resp, D_resp, L2_read, L2_write, L2_resp;
`ifdef L2_ARBITER_PERF_EN
    logic [31:0]   perf_i_grants, perf_d_grants, perf_conflicts;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: who owns L2 (0 none, 1 I, 2 D) and who went last.
    int m_owner;
    bit m_last_d;
    int m_i_grants, m_d_grants, m_conflicts;

    l2_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .I_read   (I_read),
        .I_write  (I_write),
        .I_addr   (I_addr),
        .I_wdata  (I_wdata),
        .I_rdata  (I_rdata),
        .I_resp   (I_resp),
        .D_read   (D_read),
        .D_write  (D_write),
        .D_addr   (D_addr),
        .D_wdata  (D_wdata),
        .D_rdata  (D_rdata),
        .D_resp   (D_resp),
        .L2_read  (L2_read),
        .L2_write (L2_write),
        .L2_addr  (L2_addr),
        .L2_wdata (L2_wdata),
        .L2_rdata (L2_rdata),
`ifdef L2_ARBITER_PERF_EN
        .perf_i_grants  (perf_i_grants),
        .perf_d_grants  (perf_d_grants),
        .perf_conflicts (perf_conflicts),
`endif
        .L2_resp  (L2_resp)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_inputs();
        I_read = 0; I_write = 0; I_addr = '0; I_wdata = '0;
        D_read = 0; D_write = 0; D_addr = '0; D_wdata = '0;
        L2_rdata = '0; L2_resp = 0;
    endtask

    // Leaves the bench 1 time unit after an edge with rst released.
    task automatic apply_reset();
        rst = 1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 0;
        m_owner = 0; m_last_d = 1;
        m_i_grants = 0; m_d_grants = 0; m_conflicts = 0;
    endtask

    // Arbitration rules applied at a clock edge to the inputs held there.
    task automatic model_edge();
        bit ri, rd;
        ri = I_read | I_write;
        rd = D_read | D_write;
        if (m_owner == 0) begin
            if (ri && rd) m_conflicts++;
            if (ri && rd)  m_owner = m_last_d ? 1 : 2;
            else if (ri)   m_owner = 1;
            else if (rd)   m_owner = 2;
            if (m_owner == 1) m_i_grants++;
            if (m_owner == 2) m_d_grants++;
        end else if (L2_resp) begin
            m_last_d = (m_owner == 2);
            m_owner  = 0;
        end
    endtask

    task automatic test_reset();
        rst = 1;
        I_read = 1; I_write = 1; D_read = 1; D_write = 1;
        I_addr = 16'hFFFF; D_addr = 16'hFFFF; I_wdata = '1; D_wdata = '1;
        L2_resp = 1; L2_rdata = '1;
        repeat (3) @(posedge clk);
        #4;
        n_checks++;
        if ({L2_read, L2_write, I_resp, D_resp} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000", {L2_read, L2_write, I_resp, D_resp});
        end
        n_checks++;
        if (L2_addr !== '0 || L2_wdata !== '0) begin
            n_fail++;
            $display("FAIL reset_l2_data: got addr %h wdata %h want 0", L2_addr, L2_wdata);
        end
        n_checks++;
        if (I_rdata !== '0 || D_rdata !== '0) begin
            n_fail++;
            $display("FAIL reset_rdata: got I %h D %h want 0", I_rdata, D_rdata);
        end
    endtask

    task automatic test_lone_i_read();
        logic [LW-1:0] a5;
        a5 = {16{8'hA5}};
        apply_reset();
        I_read = 1; I_addr = 16'h1230;
        #3;
        n_checks++;
        if (L2_read !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_grant_latency: got L2_read %b want 0", L2_read);
        end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            if (k == 3) begin L2_resp = 1; L2_rdata = a5; end
            #3;
            n_checks++;
            if (L2_read !== 1'b1 || L2_write !== 1'b0 || L2_addr !== 16'h1230) begin
                n_fail++;
                $display("FAIL lone_l2_req c%0d: got rd %b wr %b addr %h want 1 0 1230", k, L2_read, L2_write, L2_addr);
            end
            n_checks++;
            if (I_resp !== (k == 3) || D_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL lone_resp c%0d: got I %b D %b want %0d 0", k, I_resp, D_resp, k == 3);
            end
        end
        n_checks++;
        if (I_rdata !== a5 || D_rdata !== '0) begin
            n_fail++;
            $display("FAIL lone_rdata: got I %h D %h want %h 0", I_rdata, D_rdata, a5);
        end
        @(posedge clk); #1;
        L2_resp = 0; L2_rdata = '0;
        #3;
        n_checks++;
        if (L2_read !== 1'b0 || I_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL lone_bubble: got L2_read %b I_resp %b want 0 0", L2_read, I_resp);
        end
        I_read = 0;
    endtask

    task automatic test_simultaneous();
        logic [LW-1:0] wd, rd_i, rd_d;
        wd = {4{32'hDEADBEEF}};
        rd_i = {4{$urandom}};
        rd_d = {4{$urandom}};
        apply_reset();
        I_read = 1; I_addr = 16'h0A0A;
        D_write = 1; D_addr = 16'h0D0D; D_wdata = wd;
        @(posedge clk); #3;
        n_checks++;
        if (L2_read !== 1'b1 || L2_write !== 1'b0 || L2_addr !== 16'h0A0A) begin
            n_fail++;
            $display("FAIL simul_first_i: got rd %b wr %b addr %h want 1 0 0a0a", L2_read, L2_write, L2_addr);
        end
        @(posedge clk); #1;
        L2_resp = 1; L2_rdata = rd_i;
        #3;
        n_checks++;
        if (I_resp !== 1'b1 || D_resp !== 1'b0 || I_rdata !== rd_i || D_rdata !== '0) begin
            n_fail++;
            $display("FAIL simul_i_resp: got I %b D %b Idata %h", I_resp, D_resp, I_rdata);
        end
        @(posedge clk); #1;
        I_read = 0; L2_resp = 0;
        #3;
        n_checks++;
        if (L2_write !== 1'b0 || L2_read !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_bubble: got rd %b wr %b want 0 0", L2_read, L2_write);
        end
        @(posedge clk); #3;
        n_checks++;
        if (L2_write !== 1'b1 || L2_read !== 1'b0 || L2_wdata !== wd || L2_addr !== 16'h0D0D) begin
            n_fail++;
            $display("FAIL simul_d_write: got rd %b wr %b addr %h wdata %h", L2_read, L2_write, L2_addr, L2_wdata);
        end
        @(posedge clk); #1;
        L2_resp = 1; L2_rdata = rd_d;
        #3;
        n_checks++;
        if (D_resp !== 1'b1 || I_resp !== 1'b0 || D_rdata !== rd_d || I_rdata !== '0) begin
            n_fail++;
            $display("FAIL simul_d_resp: got D %b I %b Ddata %h Idata %h", D_resp, I_resp, D_rdata, I_rdata);
        end
        @(posedge clk); #1;
        D_write = 0; L2_resp = 0;
    endtask

    task automatic test_fairness();
        int grants[$];
        int gaps[$];
        int svc, lat, idle_run, cur;
        bit after_resp;
        svc = 0; idle_run = 0; after_resp = 0;
        lat = $urandom_range(3, 1);
        apply_reset();
        I_read = 1; D_read = 1; I_addr = 16'h1111; D_addr = 16'h2222;
        for (int cyc = 0; cyc < 200; cyc++) begin
            #3;
            if (L2_read) begin
                cur = (L2_addr == 16'h1111) ? 0 : 1;
                if (after_resp) begin gaps.push_back(idle_run); after_resp = 0; end
                if (L2_resp) begin
                    grants.push_back(cur);
                    after_resp = 1; idle_run = 0; svc = 0;
                    lat = $urandom_range(3, 1);
                end else begin
                    svc++;
                end
            end else begin
                idle_run++;
            end
            if (grants.size() == 6) break;
            @(posedge clk); #1;
            L2_resp = (svc == lat);
        end
        n_checks++;
        if (grants.size() != 6) begin
            n_fail++;
            $display("FAIL fair_count: got %0d transactions want 6 within budget", grants.size());
        end
        foreach (grants[k]) begin
            n_checks++;
            if (grants[k] != (k % 2)) begin
                n_fail++;
                $display("FAIL fair_order[%0d]: got %s want %s", k, grants[k] ? "D" : "I", (k % 2) ? "D" : "I");
            end
        end
        foreach (gaps[k]) begin
            n_checks++;
            if (gaps[k] != 1) begin
                n_fail++;
                $display("FAIL fair_bubble[%0d]: got %0d idle cycles want 1", k, gaps[k]);
            end
        end
`ifdef L2_ARBITER_PERF_EN
        n_checks++;
        if (perf_i_grants !== 32'd3 || perf_d_grants !== 32'd3 || perf_conflicts !== 32'd6) begin
            n_fail++;
            $display("FAIL fair_perf: got i %0d d %0d c %0d want 3 3 6", perf_i_grants, perf_d_grants, perf_conflicts);
        end
`endif
        @(posedge clk); #1;
        I_read = 0; D_read = 0; L2_resp = 0;
    endtask

    task automatic test_non_owner();
        logic [LW-1:0] wd;
        wd = {4{$urandom}};
        apply_reset();
        I_write = 1; I_addr = 16'h5555; I_wdata = wd;
        @(posedge clk); #1;
        D_read = 1; D_addr = 16'h6666;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(posedge clk);
            #3;
            n_checks++;
            if (L2_addr !== 16'h5555 || L2_write !== 1'b1 || L2_read !== 1'b0 || L2_wdata !== wd || D_resp !== 1'b0) begin
                n_fail++;
                $display("FAIL nonowner_hold c%0d: got addr %h rd %b wr %b Dresp %b", k, L2_addr, L2_read, L2_write, D_resp);
            end
            if (k == 0) #1;
        end
        @(posedge clk); #1;
        L2_resp = 1;
        #3;
        n_checks++;
        if (I_resp !== 1'b1 || D_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL nonowner_resp: got I %b D %b want 1 0", I_resp, D_resp);
        end
        @(posedge clk); #1;
        I_write = 0; L2_resp = 0;
        #3;
        n_checks++;
        if (L2_read !== 1'b0 || L2_addr !== '0) begin
            n_fail++;
            $display("FAIL nonowner_bubble: got rd %b addr %h want 0 0", L2_read, L2_addr);
        end
        @(posedge clk); #3;
        n_checks++;
        if (L2_read !== 1'b1 || L2_addr !== 16'h6666) begin
            n_fail++;
            $display("FAIL nonowner_then_d: got rd %b addr %h want 1 6666", L2_read, L2_addr);
        end
        @(posedge clk); #1;
        D_read = 0;
    endtask

    task automatic test_reset_mid();
        apply_reset();
        D_read = 1; D_addr = 16'hBEEF;
        @(posedge clk); #3;
        n_checks++;
        if (L2_read !== 1'b1 || L2_addr !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rstmid_serve_d: got rd %b addr %h want 1 beef", L2_read, L2_addr);
        end
        @(posedge clk); #2;
        rst = 1; L2_resp = 1;
        #1;
        n_checks++;
        if (L2_read !== 1'b0 || L2_addr !== '0 || D_resp !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got rd %b addr %h Dresp %b want 0 0 0", L2_read, L2_addr, D_resp);
        end
        @(posedge clk); #1;
        rst = 0; L2_resp = 0;
        #3;
        n_checks++;
        if (L2_read !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_release_idle: got rd %b want 0", L2_read);
        end
        @(posedge clk); #3;
        n_checks++;
        if (L2_read !== 1'b1 || L2_addr !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL rstmid_lone_d: got rd %b addr %h want 1 beef", L2_read, L2_addr);
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0; I_read = 1; I_addr = 16'h4321;
        @(posedge clk); #3;
        n_checks++;
        if (L2_read !== 1'b1 || L2_addr !== 16'h4321) begin
            n_fail++;
            $display("FAIL rstmid_conflict_i: got rd %b addr %h want 1 4321", L2_read, L2_addr);
        end
        @(posedge clk); #1;
        I_read = 0; D_read = 0;
    endtask

    task automatic test_random(input int ncyc);
        bit i_pend, d_pend, w;
        int prev_owner;
        logic prev_resp;
        logic          e_rd, e_wr, e_iresp, e_dresp;
        logic [AW-1:0] e_addr;
        logic [LW-1:0] e_wdata, e_irdata, e_drdata;
        int bad;
        i_pend = 0; d_pend = 0; bad = 0;
        apply_reset();
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk);
            prev_owner = m_owner;
            prev_resp  = L2_resp;
            model_edge();
            #1;
            if (prev_resp && prev_owner == 1) begin I_read = 0; I_write = 0; i_pend = 0; end
            if (prev_resp && prev_owner == 2) begin D_read = 0; D_write = 0; d_pend = 0; end
            if (!i_pend && $urandom_range(2) == 0) begin
                i_pend = 1; w = 1'($urandom_range(1));
                I_read = !w; I_write = w;
                I_addr = 16'($urandom); I_wdata = {4{$urandom}};
            end
            if (!d_pend && $urandom_range(2) == 0) begin
                d_pend = 1; w = 1'($urandom_range(1));
                D_read = !w; D_write = w;
                D_addr = 16'($urandom); D_wdata = {4{$urandom}};
            end
            L2_resp  = ($urandom_range(2) == 0);
            L2_rdata = {4{$urandom}};
            #3;
            e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
            e_iresp = 0; e_dresp = 0; e_irdata = '0; e_drdata = '0;
            if (m_owner == 1) begin
                e_rd = I_read; e_wr = I_write; e_addr = I_addr; e_wdata = I_wdata;
                e_iresp = L2_resp; e_irdata = L2_rdata;
            end else if (m_owner == 2) begin
                e_rd = D_read; e_wr = D_write; e_addr = D_addr; e_wdata = D_wdata;
                e_dresp = L2_resp; e_drdata = L2_rdata;
            end
            n_checks++;
            if ({L2_read, L2_write, I_resp, D_resp} !== {e_rd, e_wr, e_iresp, e_dresp}
                || L2_addr !== e_addr || L2_wdata !== e_wdata
                || I_rdata !== e_irdata || D_rdata !== e_drdata) begin
                n_fail++;
                bad++;
                if (bad <= 10)
                    $display("FAIL random c%0d: got rd%b wr%b ir%b dr%b addr %h want rd%b wr%b ir%b dr%b addr %h (owner %0d)",
                             c, L2_read, L2_write, I_resp, D_resp, L2_addr, e_rd, e_wr, e_iresp, e_dresp, e_addr, m_owner);
            end
        end
`ifdef L2_ARBITER_PERF_EN
        n_checks++;
        if (perf_i_grants !== 32'(m_i_grants) || perf_d_grants !== 32'(m_d_grants) || perf_conflicts !== 32'(m_conflicts)) begin
            n_fail++;
            $display("FAIL random_perf: got %0d %0d %0d want %0d %0d %0d", perf_i_grants, perf_d_grants, perf_conflicts,
                     m_i_grants, m_d_grants, m_conflicts);
        end
`endif
        clear_inputs();
    endtask

`ifdef L2_ARBITER_PERF_EN
    task automatic test_perf_wrap();
        apply_reset();
        force dut.u_fsm.perf_i_grants = 32'hFFFF_FFFF;
        #1 release dut.u_fsm.perf_i_grants;
        I_read = 1; I_addr = 16'h0100;
        @(posedge clk); #3;
        n_checks++;
        if (perf_i_grants !== 32'd0) begin
            n_fail++;
            $display("FAIL perf_wrap: got %h want 00000000", perf_i_grants);
        end
        I_read = 0;
    endtask
`endif

    initial begin
        rst = 1;
        clear_inputs();
        test_reset();
        test_lone_i_read();
        test_simultaneous();
        test_fairness();
        test_non_owner();
        test_reset_mid();
        test_random(2000);
`ifdef L2_ARBITER_PERF_EN
        test_perf_wrap();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
